// File: rtl/conv_complex_stream.sv
// Output serializer for the 3-tap complex convolver: captures the flat result bus
// on conv_done and streams N = NUM_ELEMS+2 complex samples over valid/ready.
module conv_complex_stream #(
    parameter  int unsigned QI        = 3,
    parameter  int unsigned QF        = 3,
    parameter  int unsigned NUM_ELEMS = 100,
    localparam int unsigned W         = QI + QF,
    localparam int unsigned N         = NUM_ELEMS + 2,
    localparam int unsigned BW        = 2 * W * N,
    localparam int unsigned IW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] conv,
    input  logic          conv_done,
    input  logic          conv_overflow,
    output logic [W-1:0]  out_re,
    output logic [W-1:0]  out_im,
    output logic [IW-1:0] out_index,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          ovf_flag,
    output logic          dropped
);

    localparam int unsigned TOP = BW - 2 * W;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [BW-1:0] shadow_q, shadow_d;
    logic [W-1:0]  re_q, re_d;
    logic [W-1:0]  im_q, im_d;
    logic [IW-1:0] index_q, index_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic          dropped_q, dropped_d;
    logic          xfer;
    logic          final_xfer;
    logic          load;

    // Shadow holds the samples not yet presented; its top slot is always the next one.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        re_d       = re_q;
        im_d       = im_q;
        index_d    = index_q;
        valid_d    = valid_q;
        last_d     = last_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;
        dropped_d  = dropped_q;
        load       = 1'b0;
        xfer       = valid_q && out_ready;
        final_xfer = xfer && (index_q == IW'(N - 1));

        case (state_q)
            IDLE: begin
                if (conv_done) begin
                    load = 1'b1;
                end
            end
            STREAM: begin
                if (final_xfer) begin
                    if (conv_done) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        index_d = '0;
                    end
                end else if (xfer) begin
                    re_d     = shadow_q[TOP +: W];
                    im_d     = shadow_q[TOP + W +: W];
                    shadow_d = shadow_q << (2 * W);
                    index_d  = index_q + IW'(1);
                    last_d   = (index_q == IW'(N - 2));
                end
                if (conv_done && !final_xfer) begin
                    dropped_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture: sample 0 goes straight to the output registers.
        if (load) begin
            state_d  = STREAM;
            re_d     = conv[TOP +: W];
            im_d     = conv[TOP + W +: W];
            shadow_d = conv << (2 * W);
            index_d  = '0;
            valid_d  = 1'b1;
            last_d   = 1'b0;
            busy_d   = 1'b1;
            ovf_d    = conv_overflow;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            re_q      <= '0;
            im_q      <= '0;
            index_q   <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            re_q      <= re_d;
            im_q      <= im_d;
            index_q   <= index_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            dropped_q <= dropped_d;
        end
    end

    assign out_re    = re_q;
    assign out_im    = im_q;
    assign out_index = index_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign ovf_flag  = ovf_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_conv_complex_stream.sv
// Scoreboard bench for conv_complex_stream with NUM_ELEMS=4, W=6 (N=6).
module tb_conv_complex_stream;

    localparam int unsigned W  = 6;
    localparam int unsigned N  = 6;
    localparam int unsigned BW = 2 * W * N;

    typedef struct {
        logic [5:0] re;
        logic [5:0] im;
        logic [2:0] idx;
        logic       last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [BW-1:0] conv = '0;
    logic          conv_done = 1'b0;
    logic          conv_overflow = 1'b0;
    logic [W-1:0]  out_re, out_im;
    logic [2:0]    out_index;
    logic          out_valid, out_last, busy, ovf_flag, dropped;
    logic          out_ready = 1'b1;

    conv_complex_stream #(.QI(3), .QF(3), .NUM_ELEMS(4)) dut (
        .clk(clk), .rst(rst), .conv(conv), .conv_done(conv_done),
        .conv_overflow(conv_overflow), .out_re(out_re), .out_im(out_im),
        .out_index(out_index), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .ovf_flag(ovf_flag), .dropped(dropped)
    );

    always #5 clk = ~clk;

    exp_t          q[$];
    int            chk_cnt = 0;
    int            pass_cnt = 0;
    int            xfer_cnt = 0;
    logic [5:0]    re_a[N];
    logic [5:0]    im_a[N];
    logic [BW-1:0] conv_v;
    bit            hold_pending = 0;
    logic [15:0]   held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic build();
        for (int k = 0; k < int'(N); k++)
            conv_v[(N - k) * 2 * W - 1 -: 2 * W] = {im_a[k], re_a[k]};
    endtask

    // Drives a one-cycle conv_done after the current edge; optionally queues the expected samples.
    task automatic pulse(input logic ovf, input bit expect_it);
        exp_t e;
        conv = conv_v;
        conv_overflow = ovf;
        conv_done = 1'b1;
        if (expect_it) begin
            for (int k = 0; k < int'(N); k++) begin
                e.re = re_a[k]; e.im = im_a[k]; e.idx = 3'(k); e.last = (k == int'(N) - 1);
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
        conv_done = 1'b0;
        conv_overflow = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && q.size() == 0) begin ok = 1; break; end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // Monitor: pops the scoreboard on each transfer and checks hold stability under backpressure.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("busy_eq_valid", 32'(busy), 32'(out_valid));
            if (hold_pending && out_valid)
                check("hold_stable", 32'({out_re, out_im, out_index, out_last}), 32'(held));
            hold_pending = 0;
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (q.size() == 0) begin
                    check("unexpected_sample", 32'({out_re, out_im, out_index, out_last}), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("sample", 32'({out_re, out_im, out_index, out_last}),
                          32'({e.re, e.im, e.idx, e.last}));
                end
            end else if (out_valid) begin
                hold_pending = 1;
                held = {out_re, out_im, out_index, out_last};
            end
        end else begin
            hold_pending = 0;
        end
    end

    initial begin
        int x0;
        #3;
        check("reset_outs", 32'({out_re, out_im, out_index, out_valid, out_last}), 32'd0);
        check("reset_flags", 32'({busy, ovf_flag, dropped}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Single set at full rate: (1,2),(3,4),...,(11,12)
        for (int k = 0; k < int'(N); k++) begin
            re_a[k] = 6'(2 * k + 1); im_a[k] = 6'(2 * k + 2);
        end
        build();
        x0 = xfer_cnt;
        pulse(1'b0, 1);
        for (int i = 0; i < int'(N); i++) begin
            @(negedge clk);
            check("t1_valid_run", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        check("t1_idle_after", 32'(out_valid), 32'd0);
        check("t1_xfers", 32'(xfer_cnt - x0), 32'd6);
        check("t1_ovf", 32'(ovf_flag), 32'd0);
        @(posedge clk); #1;

        // Backpressure with ready pattern 1,0,0,1,...
        x0 = xfer_cnt;
        pulse(1'b0, 1);
        for (int i = 0; i < 100; i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            @(posedge clk); #1;
            if (!busy) break;
        end
        out_ready = 1'b1;
        drain("t2_drain");
        check("t2_xfers", 32'(xfer_cnt - x0), 32'd6);
        @(posedge clk); #1;

        // Back-to-back: second conv_done lands on the k=5 transfer
        x0 = xfer_cnt;
        pulse(1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_valid_run", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        for (int k = 0; k < int'(N); k++) begin
            re_a[k] = 6'(40 + k); im_a[k] = 6'(50 + k);
        end
        build();
        pulse(1'b1, 1);
        @(negedge clk);
        check("t4_no_gap", 32'({out_valid, out_index}), 32'({1'b1, 3'd0}));
        check("t4_ovf_new_set", 32'(ovf_flag), 32'd1);
        drain("t4_drain");
        check("t4_xfers", 32'(xfer_cnt - x0), 32'd12);
        check("t4_dropped", 32'(dropped), 32'd0);
        @(posedge clk); #1;

        // Overflow flag and drop at k=2
        for (int k = 0; k < int'(N); k++) begin
            re_a[k] = 6'(k + 9); im_a[k] = 6'(60 - k);
        end
        build();
        x0 = xfer_cnt;
        pulse(1'b1, 1);
        @(posedge clk); @(posedge clk); #1;
        for (int k = 0; k < int'(N); k++) begin
            re_a[k] = 6'h2A; im_a[k] = 6'h15;
        end
        build();
        pulse(1'b0, 0);
        check("t3_dropped", 32'(dropped), 32'd1);
        drain("t3_drain");
        check("t3_xfers", 32'(xfer_cnt - x0), 32'd6);
        check("t3_ovf_held_idle", 32'(ovf_flag), 32'd1);
        @(posedge clk); #1;

        // Reset mid-stream at k=3
        for (int k = 0; k < int'(N); k++) begin
            re_a[k] = 6'(k + 20); im_a[k] = 6'(k + 30);
        end
        build();
        pulse(1'b0, 1);
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        check("t5_at_k3", 32'({out_valid, out_index}), 32'({1'b1, 3'd3}));
        rst = 1'b0;
        q.delete();
        #1;
        check("t5_async_outs", 32'({out_re, out_im, out_index, out_valid, out_last}), 32'd0);
        check("t5_async_flags", 32'({busy, ovf_flag, dropped}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t5_idle_after", 32'({out_valid, busy}), 32'd0);
        end
        @(posedge clk); #1;

        // Sign extremes pass bit-exact
        re_a[0] = 6'h20; im_a[0] = 6'h1F;
        re_a[1] = 6'h1F; im_a[1] = 6'h20;
        re_a[2] = 6'h20; im_a[2] = 6'h20;
        re_a[3] = 6'h1F; im_a[3] = 6'h1F;
        re_a[4] = 6'h3F; im_a[4] = 6'h00;
        re_a[5] = 6'h01; im_a[5] = 6'h3F;
        build();
        x0 = xfer_cnt;
        pulse(1'b0, 1);
        drain("t6_drain");
        check("t6_xfers", 32'(xfer_cnt - x0), 32'd6);
        check("t6_dropped", 32'(dropped), 32'd0);

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/conv_complex_stream.md
# conv_complex_stream

Output serializer downstream of the 3-tap complex fixed-point convolver. On the convolver's `done` pulse it captures the flat `conv` result bus and the overflow flag. It then streams the NUM_ELEMS+2 complex results one sample per cycle over a valid/ready interface to the next stage (FFT/readout). It also reports dropped result sets that arrive while a stream is still in progress.

## Interface
- QI, 3, integer bits of each Q-format word (sign included)
- QF, 3, fractional bits of each Q-format word
- NUM_ELEMS, 100, input signal length; result count N = NUM_ELEMS+2; word W = QI+QF
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- conv  in  2*W*N  convolver result bus, valid in the cycle `conv_done` is high
- conv_done  in  1  result-ready strobe from the convolver
- conv_overflow  in  1  convolver overflow flag, sampled with `conv_done`
- out_re  out  W  signed real part of the current sample
- out_im  out  W  signed imaginary part of the current sample
- out_index  out  $clog2(N)  index k of the current sample, 0..N-1
- out_valid  out  1  sample on out_* is valid
- out_last  out  1  high with out_valid when k = N-1
- out_ready  in  1  downstream accepts the sample
- busy  out  1  a result set is held and not yet fully transferred
- ovf_flag  out  1  overflow status of the set being streamed
- dropped  out  1  sticky: a `conv_done` was lost while busy

## Operation
- Slot layout:
  - Sample k lives in bits [(N-k)*2W-1 : (N-k-1)*2W], so the most significant slot is output first.
  - Within a slot, Re is bits [W-1:0] and Im is bits [2W-1:W].
- States:
  - IDLE: out_valid=0, busy=0.
  - STREAM: busy=1, out_valid=1.
- IDLE → STREAM when `conv_done`=1:
  - Capture `conv` into a shadow register.
  - Set k=0 and ovf_flag ← conv_overflow.
- Transfer: a sample transfers on any clock edge where out_valid && out_ready.
  - If k<N-1, advance k by 1 (shift the shadow register by one slot) and stay in STREAM.
  - If k=N-1, return to IDLE.
- Backpressure: while out_valid && !out_ready, out_re, out_im, out_index and out_last hold stable.
- `conv_done` in STREAM:
  - If it coincides with the final transfer (k=N-1 and out_ready=1), it is accepted. The new set is captured and the block stays in STREAM with k=0, with no idle gap.
  - Otherwise it is ignored, `dropped` ← 1, and the current stream continues unaffected.
- `dropped` clears only on reset.
- ovf_flag holds its value after returning to IDLE until the next capture.
- No arithmetic is performed; samples pass bit-exact.

## Timing
- Reset (rst=0, async):
  - State → IDLE.
  - out_re, out_im, out_index, out_valid, out_last, busy, ovf_flag, dropped all → 0.
  - The shadow register is cleared.
- Reset asserted mid-stream aborts the set immediately. No further samples are output after release.
- Latency: `conv_done` sampled high at edge t gives out_valid=1 with sample 0 after edge t.
- Throughput: 1 sample/cycle while out_ready=1. A set occupies exactly N cycles with no stall.
- All outputs are registered. There is no combinational path from out_ready or conv to any output.
- out_last = out_valid && (k == N-1).

## Test plan
- Single set, out_ready=1, NUM_ELEMS=4, W=6.
  - Stimulus: conv slots k0..k5 = (Re,Im) (1,2),(3,4),…,(11,12); `conv_done` one cycle.
  - Expect out_valid for 6 consecutive cycles, pairs emitted in that order, out_index 0..5.
  - Expect out_last only on index 5, busy falling with out_valid.
- Backpressure: same set with out_ready toggling 1,0,0,1,…
  - Expect each sample held stable while ready=0.
  - Expect no sample repeated or skipped; total of 6 transfers.
- Overflow and drop:
  - `conv_done` with conv_overflow=1 → ovf_flag=1.
  - A second `conv_done` at k=2 → dropped=1, and the stream still completes its original 6 samples.
- Back-to-back:
  - Second `conv_done` in the same cycle as the k=5 transfer.
  - Expect sample 0 of set 2 the next cycle, out_valid continuous, dropped=0.
- Reset mid-stream:
  - Drive rst=0 at k=3 for one cycle.
  - Expect all outputs 0 asynchronously, and the block idle after release until the next `conv_done`.
- Sign extremes: slots containing -32 (6'b100000) and 31 (6'b011111) pass bit-exact on out_re/out_im.
